usb_dfu_page_writer: RTL
========================

# usb_dfu_page_writer

Download-side sequencer between the DFU class request handler and `usb_spiflash_bridge`. Accepts one DFU_DNLOAD block at a time (block number plus byte length), maps it to a flash page inside the bitstream partition, streams the block's bytes from the OUT-data FIFO into the bridge's write port, and waits for the program cycle to finish. Reports busy/done/error so the DFU state machine can answer DFU_GETSTATUS (dfuDNBUSY vs dfuDNLOAD-IDLE vs errADDRESS).

## Interface
- PAGE_SIZE, 256, flash page size in bytes; power of two; PAGE_BITS = $clog2(PAGE_SIZE).
- BASE_PAGE, 16'h0280, first page of the partition; must be sector aligned.
- PAGE_COUNT, 16'h0580, pages in the partition.
- TIMEOUT_CYCLES, 24'd4800000, program watchdog limit (used only with the macro below).

- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- dl_start  in  1  one-cycle pulse: new block described by dl_block/dl_length.
- dl_block  in  16  DFU block number (wValue).
- dl_length  in  PAGE_BITS+1  block byte count (wLength), 0..PAGE_SIZE.
- out_data_avail  in  1  FIFO has a byte; out_data valid (first-word-fall-through).
- out_data_get  out  1  byte on out_data consumed this cycle.
- out_data  in  8  FIFO head byte.
- flash_address  out  16  page address to the bridge.
- flash_wr_request  out  1  bridge write request.
- flash_wr_busy  in  1  bridge erase/program in progress.
- flash_wr_data_avail  out  1  byte offered to the bridge.
- flash_wr_data_get  in  1  bridge takes a byte this cycle.
- flash_wr_data  out  8  byte to the bridge; valid the cycle after flash_wr_data_get.
- busy  out  1  block in progress.
- done  out  1  one-cycle pulse: block finished successfully.
- error  out  1  one-cycle pulse: block rejected or watchdog fired.

## Operation
- States: IDLE, START, STREAM, DRAIN, DONE.
- IDLE: on dl_start latch block/length, clear byte counter.
  - dl_block >= PAGE_COUNT or dl_length > PAGE_SIZE: pulse error, stay IDLE, no flash activity.
  - dl_length == 0: pulse done next cycle, no flash activity (manifest block).
  - else flash_address <= BASE_PAGE + dl_block (16-bit, no wrap check beyond PAGE_COUNT), go START.
- START: flash_wr_request=1; go STREAM when flash_wr_busy seen high.
- STREAM: flash_wr_request=1; flash_wr_data_avail = out_data_avail && (count < length); out_data_get = flash_wr_data_get (pure combinational pass-through); on get, flash_wr_data <= out_data, count++. When count == length go DRAIN.
- DRAIN: flash_wr_request=0; wait flash_wr_busy low, then DONE.
- DONE: pulse done, return IDLE.
- busy = (state != IDLE); dl_start while busy is ignored.
- Bytes arriving in START before busy rises are accepted normally (bridge takes data as soon as request is high).
- FIFO empty mid-block: stall indefinitely in STREAM; request stays high.
- Partial block (length < PAGE_SIZE): only length bytes programmed; remainder of page left erased.

## Timing
- Reset values: out_data_get 0, flash_address 0, flash_wr_request 0, flash_wr_data_avail 0, flash_wr_data 0, busy 0, done 0, error 0; state IDLE. Reset mid-block abandons it; bridge shares reset.
- dl_start -> flash_wr_request high: 1 cycle. Reject -> error: 1 cycle. Zero-length -> done: 1 cycle.
- Throughput: one byte per bridge get; no extra bubble added.
- flash_wr_data is registered: updated the edge after flash_wr_data_get, held until the next get.
- flash_wr_busy low -> done: 2 cycles (DRAIN->DONE, DONE output).
- flash_wr_request must be 0 before flash_wr_busy falls, or the bridge starts a second write.

## Configuration
- USB_DFU_PAGE_WRITER_TIMEOUT_EN defined: 24-bit counter runs in START, STREAM, DRAIN; cleared on each byte transferred and on state entry; reaching TIMEOUT_CYCLES drops flash_wr_request, pulses error, returns IDLE.
- Undefined: no counter; states wait forever; error only from range/length rejection.

## Test plan
- dl_block=3, dl_length=256, FIFO preloaded 0x00..0xFF -> flash_address=0x0283, 256 gets, flash_wr_data sequence 0x00..0xFF, done after busy falls, error never.
- dl_block=5, dl_length=10 -> exactly 10 bytes forwarded, flash_wr_data_avail stays 0 after 10th get, FIFO keeps 11th byte.
- dl_block=0x0580 -> error pulse 1 cycle after dl_start, flash_wr_request never rises; dl_length=257 -> same.
- dl_length=0 -> done 1 cycle later, no request; dl_start during STREAM -> ignored, block completes unchanged.
- FIFO empties after 100 of 256 bytes for 500 cycles -> request held, resumes, all 256 delivered; reset asserted at byte 50 -> all outputs reset next cycle.
- With USB_DFU_PAGE_WRITER_TIMEOUT_EN, TIMEOUT_CYCLES=1000, flash_wr_busy stuck high -> error at cycle 1000 of DRAIN, request low, busy low.

Source files
------------

// File: rtl/usb_dfu_page_writer_if.sv
// Bus bundle between the DFU download sequencer, the OUT-data FIFO and the SPI flash bridge.
// master: the page writer itself; slave: the surrounding request handler, FIFO and bridge.
interface usb_dfu_page_writer_if #(
   parameter int unsigned PAGE_SIZE = 256
);
   localparam int unsigned PAGE_BITS = $clog2(PAGE_SIZE);

   logic                 dl_start;
   logic [15:0]          dl_block;
   logic [PAGE_BITS:0]   dl_length;
   logic                 out_data_avail;
   logic                 out_data_get;
   logic [7:0]           out_data;
   logic [15:0]          flash_address;
   logic                 flash_wr_request;
   logic                 flash_wr_busy;
   logic                 flash_wr_data_avail;
   logic                 flash_wr_data_get;
   logic [7:0]           flash_wr_data;
   logic                 busy;
   logic                 done;
   logic                 error;

   modport master (
      input  dl_start, dl_block, dl_length,
      input  out_data_avail, out_data,
      input  flash_wr_busy, flash_wr_data_get,
      output out_data_get, flash_address, flash_wr_request,
      output flash_wr_data_avail, flash_wr_data,
      output busy, done, error
   );

   modport slave (
      output dl_start, dl_block, dl_length,
      output out_data_avail, out_data,
      output flash_wr_busy, flash_wr_data_get,
      input  out_data_get, flash_address, flash_wr_request,
      input  flash_wr_data_avail, flash_wr_data,
      input  busy, done, error
   );
endinterface

// File: rtl/usb_dfu_page_writer.sv
// DFU download page writer: maps one DFU_DNLOAD block onto a flash page of the bitstream
// partition, streams its bytes from the OUT FIFO into the SPI flash bridge and waits for the
// program cycle to end. Define USB_DFU_PAGE_WRITER_TIMEOUT_EN to add a program watchdog.
module usb_dfu_page_writer #(
   parameter int unsigned PAGE_SIZE  = 256,
   parameter logic [15:0] BASE_PAGE  = 16'h0280,
   parameter logic [15:0] PAGE_COUNT = 16'h0580
`ifdef USB_DFU_PAGE_WRITER_TIMEOUT_EN
   ,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd4800000
`endif
) (
   input logic                   clk,
   input logic                   reset,
   usb_dfu_page_writer_if.master bus
);
   localparam int unsigned PAGE_BITS = $clog2(PAGE_SIZE);
   localparam int unsigned LEN_W     = PAGE_BITS + 1;
   localparam logic [LEN_W-1:0] PAGE_SIZE_LEN = LEN_W'(PAGE_SIZE);

   typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [LEN_W-1:0] length;
   logic [LEN_W-1:0] count;
   logic             accept_c;
   logic             valid_c;
   logic             more_c;
   logic             active_c;
   logic             xfer_c;
   logic             timeout_c;

   // Request decode and byte-transfer qualifiers
   always_comb begin
      accept_c = (state == IDLE) && bus.dl_start;
      valid_c  = (bus.dl_block < PAGE_COUNT) && (bus.dl_length <= PAGE_SIZE_LEN);
      more_c   = (count < length);
      active_c = (state == START) || (state == STREAM);
      xfer_c   = active_c && bus.flash_wr_data_get && more_c;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept_c && valid_c && (bus.dl_length != '0)) state_next = START;
         START:   if (bus.flash_wr_busy) state_next = STREAM;
         STREAM:  if (!more_c) state_next = DRAIN;
         DRAIN:   if (!bus.flash_wr_busy) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (timeout_c) state_next = IDLE;
   end

   // Combinational handshake outputs; the bridge may take bytes as soon as request is high
   always_comb begin
      bus.flash_wr_request    = 1'b0;
      bus.flash_wr_data_avail = 1'b0;
      bus.out_data_get        = 1'b0;
      bus.busy                = (state != IDLE);
      if (active_c) begin
         bus.flash_wr_request    = 1'b1;
         bus.flash_wr_data_avail = bus.out_data_avail && more_c;
         bus.out_data_get        = bus.flash_wr_data_get;
      end
   end

   // Block registers, byte counter, registered write data and status pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         length            <= '0;
         count             <= '0;
         bus.flash_address <= '0;
         bus.flash_wr_data <= '0;
         bus.done          <= 1'b0;
         bus.error         <= 1'b0;
      end else begin
         bus.done  <= (state == DONE) || (accept_c && valid_c && (bus.dl_length == '0));
         bus.error <= (accept_c && !valid_c) || timeout_c;
         if (accept_c) begin
            length <= bus.dl_length;
            count  <= '0;
            if (valid_c) bus.flash_address <= BASE_PAGE + bus.dl_block;
         end else if (xfer_c) begin
            bus.flash_wr_data <= bus.out_data;
            count             <= count + LEN_W'(1);
         end
      end
   end

`ifdef USB_DFU_PAGE_WRITER_TIMEOUT_EN
   logic [23:0] timer;
   logic        waiting_c;

   // Watchdog qualifiers: runs while a flash write is outstanding
   always_comb begin
      waiting_c = active_c || (state == DRAIN);
      timeout_c = waiting_c && (timer == (TIMEOUT_CYCLES - 24'd1));
   end

   // Watchdog counter, restarted on every state entry and every byte moved
   always_ff @(posedge clk) begin
      if (reset) timer <= '0;
      else if (!waiting_c || xfer_c || (state_next != state)) timer <= '0;
      else timer <= timer + 24'd1;
   end
`else
   assign timeout_c = 1'b0;
`endif

endmodule
